// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem word requests for fetch_pc, buffers responses with their PC, feeds decode.
// Latency: response to id_valid 1 cycle; request accepted at N -> id_valid at N+2 with 1-cycle memory.
// Backpressure: a request issues only when a FIFO slot is reserved for its response; id_ready=0 stalls issue and holds PC.
//
// Ports:
//   clk, reset (async active-low)      clock / reset
//   fetch_pc, pc_advance               PC from the PC register; pc_advance tells next-PC mux to select PC+4
//   redirect_valid                     taken branch/jump: flush FIFO, withdraw request, drain in-flight response
//   imem_req_* / imem_rsp_*            instruction memory request (valid/ready) and response (valid only)
//   id_valid/instr/pc/fault, id_ready  FIFO head presented to decode over valid/ready
module fetch_stage #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  output logic        pc_advance,
  input  logic        redirect_valid,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault,
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_q, out_d;
  logic [31:0]     req_pc_q, req_pc_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic [DEPTH-1:0] fault_mem;

  logic            pop, push, rsp_push, fault_push, can_issue, aligned, req_hs;
  logic [AW+1:0]   occupancy;
  logic [31:0]     push_instr, push_pc;

  assign id_valid = (count_q != '0);
  assign id_instr = instr_mem[rd_ptr_q];
  assign id_pc    = pc_mem[rd_ptr_q];
  assign id_fault = fault_mem[rd_ptr_q] & id_valid;

  assign pop     = id_valid & id_ready;
  assign aligned = (fetch_pc[1:0] == 2'b00);

  // Slots already spoken for: buffered entries plus the response still in flight,
  // less the entry decode takes this cycle. Issuing only below DEPTH means every
  // response is guaranteed a slot, so push never meets a full FIFO.
  assign occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, out_q} - {{(AW+1){1'b0}}, pop};
  assign can_issue = (occupancy < (AW+2)'(DEPTH));

  // Outputs are gated by reset so nothing is requested or consumed while reset is held.
  assign imem_req_valid = reset & can_issue & ~redirect_valid & aligned & (~out_q | imem_rsp_valid);
  assign imem_req_addr  = fetch_pc;
  assign fault_push     = reset & ~aligned & can_issue & ~redirect_valid & ~out_q;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign pc_advance     = req_hs | fault_push;

  // A response counts only if one is owed to us (out_q) and it is not stale.
  assign rsp_push   = imem_rsp_valid & out_q & (state_q == S_RUN) & ~redirect_valid;
  assign push       = rsp_push | fault_push;
  assign push_instr = fault_push ? NOP_INSTR : imem_rsp_data;
  assign push_pc    = fault_push ? fetch_pc  : req_pc_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    out_d    = out_q;
    req_pc_d = req_pc_q;

    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    if (req_hs) begin
      out_d    = 1'b1;
      req_pc_d = fetch_pc;
    end else if (imem_rsp_valid) begin
      out_d    = 1'b0;
    end

    case (state_q)
      S_RUN:   if (redirect_valid & out_q & ~imem_rsp_valid) state_d = S_DRAIN;
      // The stale response closes the drain even if another redirect lands with it.
      S_DRAIN: if (imem_rsp_valid) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Storage needs no reset: id_valid and id_fault are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= push_instr;
      pc_mem[wr_ptr_q]    <= push_pc;
      fault_mem[wr_ptr_q] <= fault_push;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pc_advance;
  logic        redirect_valid = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        id_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pc_advance(pc_advance),
    .redirect_valid(redirect_valid), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_fault(id_fault),
    .id_ready(id_ready)
  );

  int vec  = 0;
  int miss = 0;

  // Reference model: decode-visible entries as a queue {instr, pc, fault},
  // one bit for the request owed by memory, one bit for "that response is stale".
  typedef logic [64:0] ent_t;
  ent_t        q[$];
  bit          m_out;
  logic [31:0] m_out_pc;
  bit          m_drain;

  // Environment: PC register, memory with per-request latency.
  logic [31:0] pc_reg;
  bit          redir, idr, mready;
  logic [31:0] tgt;
  int          lat;
  bit          mp;
  int          mcnt;
  logic [31:0] maddr;

  bit e_pop, e_req, e_fault, e_adv, d_hs, d_adv, rsp_now;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF ^ (a << 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive this cycle's inputs, let them settle, compare DUT against the model.
  task automatic cyc_begin();
    ent_t h;
    int   occ;
    bit   aligned;
    fetch_pc       = pc_reg;
    redirect_valid = redir;
    imem_req_ready = mready;
    id_ready       = idr;
    imem_rsp_valid = mp && (mcnt == 0);
    imem_rsp_data  = mdata(maddr);
    #1;
    rsp_now = imem_rsp_valid;
    aligned = (pc_reg[1:0] == 2'b00);
    e_pop   = (q.size() > 0) && idr;
    occ     = q.size() + int'(m_out) - int'(e_pop);
    e_req   = (occ < DEPTH) && !redir && aligned && (!m_out || rsp_now);
    e_fault = (occ < DEPTH) && !redir && !aligned && !m_out;
    e_adv   = (e_req && mready) || e_fault;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
    if (e_req) chk("req_addr", imem_req_addr, pc_reg);
    chk("pc_advance", {31'b0, pc_advance}, {31'b0, e_adv});
    chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      h = q[0];
      chk("id_instr", id_instr, h[64:33]);
      chk("id_pc", id_pc, h[32:1]);
      chk("id_fault", {31'b0, id_fault}, {31'b0, h[0]});
    end
    d_hs  = imem_req_valid && mready;
    d_adv = pc_advance;
  endtask

  // Clock edge: advance model and environment, return at the following negedge.
  task automatic cyc_end();
    @(posedge clk);
    if (redir) q.delete();
    else begin
      if (e_pop) void'(q.pop_front());
      if (rsp_now && m_out && !m_drain) q.push_back({mdata(m_out_pc), m_out_pc, 1'b0});
      if (e_fault) q.push_back({NOP, pc_reg, 1'b1});
    end
    if (m_drain) begin
      if (rsp_now) m_drain = 0;
    end else if (redir && m_out && !rsp_now) m_drain = 1;
    if (e_req && mready) begin
      m_out = 1; m_out_pc = pc_reg;
    end else if (rsp_now) m_out = 0;
    if (rsp_now) mp = 0;
    else if (mp && mcnt > 0) mcnt--;
    if (d_hs) begin
      mp = 1; mcnt = lat - 1; maddr = pc_reg;
    end
    if (redir) pc_reg = tgt;
    else if (d_adv) pc_reg = pc_reg + 32'd4;
    @(negedge clk);
  endtask

  task automatic cyc();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset(input logic [31:0] pc0, input bit keep_mem);
    reset = 1'b0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_pc_advance", {31'b0, pc_advance}, 32'd0);
    chk("rst_id_fault", {31'b0, id_fault}, 32'd0);
    q.delete(); m_out = 0; m_drain = 0;
    if (!keep_mem) mp = 0;
    pc_reg = pc0; redir = 0; tgt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int first_pc;
    redir = 0; idr = 1; mready = 1; lat = 1; mp = 0; mcnt = 0; maddr = '0;
    @(negedge clk);

    // Streaming with 1-cycle memory.
    do_reset(32'h0, 0);
    idr = 1; mready = 1; lat = 1;
    cyc_begin();
    chk("t1_c0_req", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_c0_addr", imem_req_addr, 32'h0);
    cyc_end();
    cyc_begin(); chk("t1_c1_idv", {31'b0, id_valid}, 32'd0); cyc_end();
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      chk("t1_idv", {31'b0, id_valid}, 32'd1);
      chk("t1_idpc", id_pc, 32'(i * 4));
      chk("t1_adv", {31'b0, pc_advance}, 32'd1);
      cyc_end();
    end
    chk("t1_instr0_model", mdata(32'h0), 32'h13579BDF);

    // Decode stall fills exactly DEPTH entries.
    do_reset(32'h0, 0);
    idr = 0;
    repeat (3) cyc();
    cyc_begin();
    chk("t2_stall_req", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_stall_adv", {31'b0, pc_advance}, 32'd0);
    chk("t2_head", id_pc, 32'h0);
    cyc_end();
    idr = 1;
    cyc_begin();
    chk("t2_head0", id_pc, 32'h0);
    chk("t2_resume_addr", imem_req_addr, 32'h8);
    cyc_end();
    cyc_begin(); chk("t2_head4", id_pc, 32'h4); cyc_end();
    cyc_begin(); chk("t2_head8", id_pc, 32'h8); cyc_end();

    // Memory not ready for 3 cycles.
    do_reset(32'h40, 0);
    mready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      chk("t3_hold_vld", {31'b0, imem_req_valid}, 32'd1);
      chk("t3_hold_addr", imem_req_addr, 32'h40);
      chk("t3_hold_adv", {31'b0, pc_advance}, 32'd0);
      cyc_end();
    end
    mready = 1;
    cyc_begin(); chk("t3_hs_adv", {31'b0, pc_advance}, 32'd1); cyc_end();
    cyc();
    cyc_begin(); chk("t3_entry_pc", id_pc, 32'h40); cyc_end();

    // Redirect while a response is in flight.
    do_reset(32'h10, 0);
    lat = 3;
    cyc();
    redir = 1; tgt = 32'h80;
    cyc();
    redir = 0;
    cyc_begin(); chk("t4_drain_noreq", {31'b0, imem_req_valid}, 32'd0); cyc_end();
    first_pc = -1;
    for (int i = 0; i < 8; i++) begin
      cyc_begin();
      if (id_valid && first_pc < 0) first_pc = int'(id_pc);
      cyc_end();
    end
    chk("t4_first_pc", 32'(first_pc), 32'h80);
    lat = 1;

    // Misaligned PC.
    do_reset(32'h22, 0);
    cyc_begin();
    chk("t5_noreq", {31'b0, imem_req_valid}, 32'd0);
    chk("t5_adv", {31'b0, pc_advance}, 32'd1);
    cyc_end();
    cyc_begin();
    chk("t5_instr", id_instr, NOP);
    chk("t5_pc", id_pc, 32'h22);
    chk("t5_fault", {31'b0, id_fault}, 32'd1);
    cyc_end();

    // Reset mid-request with a buffered entry; stale response after release.
    do_reset(32'h0, 0);
    idr = 0; lat = 2;
    repeat (3) cyc();
    cyc_begin();
    #2;
    do_reset(32'h100, 1);
    mready = 0; idr = 1; lat = 1;
    repeat (2) cyc();
    cyc_begin(); chk("t6_stale_ignored", {31'b0, id_valid}, 32'd0); cyc_end();
    mready = 1;
    cyc();
    cyc();
    cyc_begin(); chk("t6_first_pc", id_pc, 32'h100); cyc_end();

    // Randomized traffic.
    do_reset(32'h0, 0);
    for (int i = 0; i < 4000; i++) begin
      idr    = ($urandom % 4) != 0;
      mready = ($urandom % 3) != 0;
      lat    = 1 + ($urandom % 3);
      redir  = ($urandom % 10) == 0;
      tgt    = ($urandom & 32'h00000FFC) | ((($urandom % 6) == 0) ? 32'h2 : 32'h0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
